ent_grid_arbiter: RTL and testbench

Arbitrates a single-port, synchronous-read entity grid RAM between the VGA draw path and the game logic. The draw path reads one 2-bit entity code per 16×16-pixel cell with fixed latency and absolute priority; game logic writes cells through a req/ack handshake; a clear engine fills the whole grid with EMPTY. It sits between the game state logic and vga_draw, supplying the per-pixel entity code.

---
 rtl/ent_pkg.sv | 27 ++
 rtl/ent_cell_addr.sv | 23 ++
 rtl/ent_grid_arbiter.sv | 126 ++++++++++++
 tb/tb_ent_grid_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ent_pkg.sv
// Shared definitions for the entity grid: geometry, entity codes and the
// arbiter state encoding.
package ent_pkg;

  localparam int GRID_W     = 40;
  localparam int GRID_H     = 30;
  localparam int CELL_SHIFT = 4;
  localparam int ADDR_W     = 11;
  localparam int CODE_W     = 2;
  localparam int CELLS      = GRID_W * GRID_H;

  typedef enum logic [CODE_W-1:0] {
    ENT_EMPTY = 2'd0,
    ENT_P1    = 2'd1,
    ENT_P2    = 2'd2,
    ENT_WALL  = 2'd3
  } ent_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RDWAIT,
    ST_CLR,
    ST_WR
  } arb_state_e;

endpackage

// File: rtl/ent_cell_addr.sv
// Cell (column, row) to linear grid address, row * 40 + column, built from
// shifts and adds so no multiplier is inferred.
module ent_cell_addr
  import ent_pkg::*;
#(
  parameter int COORD_W = 10 - CELL_SHIFT
) (
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  output logic [ADDR_W-1:0]  addr
);

  logic [ADDR_W-1:0] row_w;
  logic [ADDR_W-1:0] col_w;

  // 40 = 32 + 8; the result wraps at ADDR_W bits
  always_comb begin
    row_w = ADDR_W'(row);
    col_w = ADDR_W'(col);
    addr  = (row_w << 5) + (row_w << 3) + col_w;
  end

endmodule

// File: rtl/ent_grid_arbiter.sv
// Single-port entity grid RAM arbiter: fixed-latency draw reads take every slot
// they need, then clear steps, then handshake writes from the game logic.
module ent_grid_arbiter
  import ent_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_reset_n,
  input  logic              pix_ce,
  input  logic              draw_en,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [CODE_W-1:0] draw_code,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_code,
  output logic              wr_ack,
  output logic              wr_err,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [CODE_W-1:0] mem_wdata,
  input  logic [CODE_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] CNT_END = (ADDR_W+1)'(CELLS);

  arb_state_e        state, state_nx;
  logic [ADDR_W:0]   clr_cnt, clr_cnt_nx;
  logic              clr_busy_nx;
  logic [ADDR_W-1:0] mem_addr_nx;
  logic              mem_we_nx;
  logic [CODE_W-1:0] mem_wdata_nx;
  logic              wr_ack_nx, wr_err_nx;
  logic [CODE_W-1:0] draw_code_nx;
  logic [ADDR_W-1:0] cell_addr;
  logic [ADDR_W-1:0] step_addr;
  logic              trigger, clr_start, clr_step, wr_blocked;
  logic              unused_pix_lsbs;

  assign unused_pix_lsbs = ^draw_y[CELL_SHIFT-1:0];

  ent_cell_addr u_cell_addr (
    .col  (draw_x[9:CELL_SHIFT]),
    .row  (draw_y[9:CELL_SHIFT]),
    .addr (cell_addr)
  );

  assign trigger   = pix_ce && draw_en && (draw_x[CELL_SHIFT-1:0] == '0);
  assign clr_start = clr_req && !clr_busy;
  // The start cycle already owns step 0, so an uncontested clear lasts CELLS cycles
  assign clr_step  = clr_start || (clr_busy && (clr_cnt != CNT_END));
  assign step_addr = clr_start ? '0 : clr_cnt[ADDR_W-1:0];
  // A write just acked is still being held by the requester for this sample
  assign wr_blocked = clr_busy || clr_start || (state == ST_WR);

  always_comb begin
    state_nx     = ST_IDLE;
    clr_busy_nx  = clr_busy;
    clr_cnt_nx   = clr_cnt;
    mem_addr_nx  = mem_addr;
    mem_we_nx    = 1'b0;
    mem_wdata_nx = mem_wdata;
    wr_ack_nx    = 1'b0;
    wr_err_nx    = 1'b0;
    draw_code_nx = draw_code;

    if (clr_start) begin
      clr_busy_nx = 1'b1;
      clr_cnt_nx  = '0;
    end else if (clr_busy && (clr_cnt == CNT_END)) begin
      clr_busy_nx = 1'b0;
    end

    if (state == ST_RDWAIT) draw_code_nx = mem_rdata;

    // RD is the only cycle with no access slot; a trigger in RDWAIT is a protocol error
    if (state == ST_RD) begin
      state_nx = ST_RDWAIT;
    end else if (trigger && (state != ST_RDWAIT)) begin
      state_nx    = ST_RD;
      mem_addr_nx = cell_addr;
    end else if (clr_step) begin
      state_nx     = ST_CLR;
      mem_we_nx    = 1'b1;
      mem_addr_nx  = step_addr;
      mem_wdata_nx = ENT_EMPTY;
      clr_cnt_nx   = {1'b0, step_addr} + (ADDR_W+1)'(1);
    end else if (wr_req && !wr_blocked) begin
      state_nx  = ST_WR;
      wr_ack_nx = 1'b1;
      if ({1'b0, wr_addr} < CNT_END) begin
        mem_we_nx    = 1'b1;
        mem_addr_nx  = wr_addr;
        mem_wdata_nx = wr_code;
      end else begin
        wr_err_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state     <= ST_IDLE;
      clr_busy  <= 1'b0;
      clr_cnt   <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      wr_ack    <= 1'b0;
      wr_err    <= 1'b0;
      draw_code <= '0;
    end else begin
      state     <= state_nx;
      clr_busy  <= clr_busy_nx;
      clr_cnt   <= clr_cnt_nx;
      mem_addr  <= mem_addr_nx;
      mem_we    <= mem_we_nx;
      mem_wdata <= mem_wdata_nx;
      wr_ack    <= wr_ack_nx;
      wr_err    <= wr_err_nx;
      draw_code <= draw_code_nx;
    end
  end

endmodule

// File: tb/tb_ent_grid_arbiter.sv
// Directed bench for ent_grid_arbiter with a behavioural synchronous-read RAM.
module tb_ent_grid_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n;
  logic        pix_ce, draw_en;
  logic [9:0]  draw_x, draw_y;
  logic [1:0]  draw_code;
  logic        wr_req;
  logic [10:0] wr_addr;
  logic [1:0]  wr_code;
  logic        wr_ack, wr_err;
  logic        clr_req, clr_busy;
  logic [10:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_wdata;
  logic [1:0]  mem_rdata;

  logic [1:0]  ram [0:2047];

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  ent_grid_arbiter dut (
    .sys_clk     (sys_clk),
    .sys_reset_n (sys_reset_n),
    .pix_ce      (pix_ce),
    .draw_en     (draw_en),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .draw_code   (draw_code),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_code     (wr_code),
    .wr_ack      (wr_ack),
    .wr_err      (wr_err),
    .clr_req     (clr_req),
    .clr_busy    (clr_busy),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    sys_reset_n = 1'b0;
    pix_ce = 0; draw_en = 1; draw_x = 0; draw_y = 0;
    wr_req = 0; wr_addr = 0; wr_code = 0; clr_req = 0;
    tick(); tick();
    total++; if (draw_code !== 2'd0) begin bad++; $display("FAIL reset_draw_code got=%0d want=0", draw_code); end
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL reset_wr_ack got=%0b want=0", wr_ack); end
    total++; if (wr_err !== 1'b0) begin bad++; $display("FAIL reset_wr_err got=%0b want=0", wr_err); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL reset_clr_busy got=%0b want=0", clr_busy); end
    total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%0b want=0", mem_we); end
    total++; if (mem_addr !== 11'd0) begin bad++; $display("FAIL reset_mem_addr got=%0d want=0", mem_addr); end
    total++; if (mem_wdata !== 2'd0) begin bad++; $display("FAIL reset_mem_wdata got=%0d want=0", mem_wdata); end
    sys_reset_n = 1'b1;
    tick();
  endtask

  // Uncontested write of cell 41, then a back-to-back request for cell 100
  task automatic test_write;
    wr_req = 1; wr_addr = 11'd41; wr_code = 2'd2;
    tick();
    total++; if (wr_ack !== 1'b1) begin bad++; $display("FAIL wr41_ack got=%0b want=1", wr_ack); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 11'd41 || mem_wdata !== 2'd2) begin
      bad++; $display("FAIL wr41_bus got we=%0b addr=%0d data=%0d want we=1 addr=41 data=2", mem_we, mem_addr, mem_wdata); end
    wr_req = 0;
    tick();
    total++; if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL wr41_release got ack=%0b we=%0b want 0 0", wr_ack, mem_we); end
    wr_req = 1; wr_addr = 11'd100; wr_code = 2'd3;
    tick();
    total++; if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin
      bad++; $display("FAIL wr100_ack got ack=%0b err=%0b want 1 0", wr_ack, wr_err); end
    total++; if (mem_we !== 1'b1 || mem_addr !== 11'd100 || mem_wdata !== 2'd3) begin
      bad++; $display("FAIL wr100_bus got we=%0b addr=%0d data=%0d want we=1 addr=100 data=3", mem_we, mem_addr, mem_wdata); end
    wr_req = 0;
    tick();
    total++; if (wr_ack !== 1'b0 || mem_we !== 1'b0) begin
      bad++; $display("FAIL wr100_release got ack=%0b we=%0b want 0 0", wr_ack, mem_we); end
  endtask

  task automatic test_draw_read;
    // draw_en low: aligned pixel must not start a read
    draw_en = 0; pix_ce = 1; draw_x = 10'd16; draw_y = 10'd16;
    tick();
    total++; if (mem_addr !== 11'd100) begin bad++; $display("FAIL no_trig_en got addr=%0d want=100", mem_addr); end
    // unaligned column: no read either
    draw_en = 1; draw_x = 10'd17;
    tick();
    total++; if (mem_addr !== 11'd100) begin bad++; $display("FAIL no_trig_x got addr=%0d want=100", mem_addr); end
    draw_x = 10'd16;
    tick();
    pix_ce = 0;
    total++; if (mem_addr !== 11'd41 || mem_we !== 1'b0) begin
      bad++; $display("FAIL rd41_addr got addr=%0d we=%0b want 41 0", mem_addr, mem_we); end
    tick();
    total++; if (draw_code !== 2'd0) begin bad++; $display("FAIL rd41_early got=%0d want=0", draw_code); end
    tick();
    total++; if (draw_code !== 2'd2) begin bad++; $display("FAIL rd41_code got=%0d want=2", draw_code); end
    pix_ce = 1; draw_x = 10'd320; draw_y = 10'd32;
    tick();
    pix_ce = 0;
    total++; if (mem_addr !== 11'd100) begin bad++; $display("FAIL rd100_addr got=%0d want=100", mem_addr); end
    tick(); tick();
    total++; if (draw_code !== 2'd3) begin bad++; $display("FAIL rd100_code got=%0d want=3", draw_code); end
    draw_en = 0;
    repeat (3) tick();
    total++; if (draw_code !== 2'd3) begin bad++; $display("FAIL draw_hold got=%0d want=3", draw_code); end
    draw_en = 1;
  endtask

  task automatic test_back_to_back;
    pix_ce = 1; draw_x = 10'd16; draw_y = 10'd16;
    wr_req = 1; wr_addr = 11'd200; wr_code = 2'd1;
    tick();
    pix_ce = 0;
    total++; if (mem_addr !== 11'd41 || mem_we !== 1'b0 || wr_ack !== 1'b0) begin
      bad++; $display("FAIL cont_t1 got addr=%0d we=%0b ack=%0b want 41 0 0", mem_addr, mem_we, wr_ack); end
    tick();
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL cont_t2_ack got=%0b want=0", wr_ack); end
    tick();
    total++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd200 || mem_wdata !== 2'd1) begin
      bad++; $display("FAIL cont_t3_wr got ack=%0b we=%0b addr=%0d data=%0d want 1 1 200 1", wr_ack, mem_we, mem_addr, mem_wdata); end
    total++; if (draw_code !== 2'd2) begin bad++; $display("FAIL cont_t3_code got=%0d want=2", draw_code); end
    wr_req = 0;
    tick();
  endtask

  task automatic test_error;
    wr_req = 1; wr_addr = 11'd1200; wr_code = 2'd1;
    tick();
    total++; if (wr_ack !== 1'b1 || wr_err !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL err_pulse got ack=%0b err=%0b we=%0b want 1 1 0", wr_ack, wr_err, mem_we); end
    wr_req = 0;
    tick();
    total++; if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin
      bad++; $display("FAIL err_release got ack=%0b err=%0b want 0 0", wr_ack, wr_err); end
  endtask

  // Clear with 10 stolen read slots and a write held throughout
  task automatic test_clear;
    int exp_addr  = 0;
    int seq_bad   = 0;
    int busy_cnt  = 0;
    int ntrig     = 0;
    int early_ack = 0;
    bit done      = 0;
    draw_x = 10'd0; draw_y = 10'd0;
    clr_req = 1; wr_req = 1; wr_addr = 11'd300; wr_code = 2'd3;
    for (int k = 0; k < 3000 && !done; k++) begin
      pix_ce = (k >= 5 && ((k - 5) % 16) == 0 && ntrig < 10);
      if (pix_ce) ntrig++;
      tick();
      clr_req = 0; pix_ce = 0;
      if (wr_ack) early_ack++;
      if (mem_we) begin
        if (mem_addr !== 11'(exp_addr) || mem_wdata !== 2'd0) seq_bad++;
        exp_addr++;
      end
      if (clr_busy) busy_cnt++;
      else done = 1;
    end
    total++; if (!done) begin bad++; $display("FAIL clr_timeout busy never dropped"); end
    total++; if (exp_addr != 1200 || seq_bad != 0) begin
      bad++; $display("FAIL clr_writes got count=%0d out_of_order=%0d want 1200 0", exp_addr, seq_bad); end
    total++; if (busy_cnt != 1220) begin bad++; $display("FAIL clr_duration got=%0d want=1220", busy_cnt); end
    total++; if (early_ack != 0) begin bad++; $display("FAIL clr_wr_early got acks=%0d want=0", early_ack); end
    tick();
    total++; if (wr_ack !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd300) begin
      bad++; $display("FAIL clr_wr_after got ack=%0b we=%0b addr=%0d want 1 1 300", wr_ack, mem_we, mem_addr); end
    wr_req = 0;
    tick();
    pix_ce = 1; draw_x = 10'd320; draw_y = 10'd32;
    tick(); pix_ce = 0; tick(); tick();
    total++; if (draw_code !== 2'd0) begin bad++; $display("FAIL clr_cell100 got=%0d want=0", draw_code); end
    pix_ce = 1; draw_x = 10'd320; draw_y = 10'd112;
    tick(); pix_ce = 0; tick(); tick();
    total++; if (draw_code !== 2'd3) begin bad++; $display("FAIL rd300_code got=%0d want=3", draw_code); end
  endtask

  task automatic test_reset_mid_clear;
    bit hit = 0;
    clr_req = 1;
    tick();
    clr_req = 0;
    for (int k = 0; k < 1000 && !hit; k++) begin
      if (mem_we && mem_addr == 11'd500) hit = 1;
      else tick();
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_clr_reach counter 500 not seen"); end
    #2 sys_reset_n = 1'b0;
    #1;
    total++; if (clr_busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 11'd0 || draw_code !== 2'd0) begin
      bad++; $display("FAIL async_reset got busy=%0b we=%0b addr=%0d code=%0d want 0 0 0 0", clr_busy, mem_we, mem_addr, draw_code); end
    total++; if (wr_ack !== 1'b0 || wr_err !== 1'b0 || mem_wdata !== 2'd0) begin
      bad++; $display("FAIL async_reset_ctl got ack=%0b err=%0b wdata=%0d want 0 0 0", wr_ack, wr_err, mem_wdata); end
    tick();
    sys_reset_n = 1'b1;
    tick();
    clr_req = 1;
    tick();
    clr_req = 0;
    total++; if (clr_busy !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 11'd0) begin
      bad++; $display("FAIL clr_restart got busy=%0b we=%0b addr=%0d want 1 1 0", clr_busy, mem_we, mem_addr); end
    tick();
    total++; if (mem_addr !== 11'd1) begin bad++; $display("FAIL clr_restart_next got addr=%0d want=1", mem_addr); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_draw_read();
    test_back_to_back();
    test_error();
    test_clear();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
